// File: rtl/mux_scanner_pkg.sv
// Shared types for the channel mux scanner.
// State encoding and mode constants.
package mux_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_SCAN
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/param_mux_scanner_next_ch.sv
// Priority search for the next enabled channel above cur.
// Falls back to the lowest set bit, flagging the wrap.
module next_enabled_ch #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrapped,
  output logic              any
);

  logic [SEL_W-1:0] lo;
  logic [SEL_W-1:0] hi;
  logic             found;

  always_comb begin
    lo    = '0;
    hi    = '0;
    found = 1'b0;
    // descending walk leaves the lowest hit last
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo = SEL_W'(i);
        if (SEL_W'(i) > cur) begin
          hi    = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
    nxt     = found ? hi : lo;
    wrapped = ~found;
    any     = |mask;
  end

endmodule

// File: rtl/param_mux_scanner.sv
// Registered NUM_CH:1 mux with manual select and auto-scan.
// MUX_SCANNER_PARITY_EN adds a registered parity_out.
module param_mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int WIDTH  = 8,
  parameter int DWELL  = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
`ifdef MUX_SCANNER_PARITY_EN
  output logic                    parity_out,
`endif
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        ch_out,
  output logic                    out_valid,
  output logic                    wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0] CH_LIM = NUM_CH[SEL_W:0];
  localparam logic [SEL_W-1:0] CH_TOP = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0] chan [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign chan[i] = data_in[i*WIDTH +: WIDTH];
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             seek, seek_n;
  logic [WIDTH-1:0] data_n;
  logic [SEL_W-1:0] ch_n;
  logic             valid_n;
  logic             wrap_n;
  logic [SEL_W-1:0] sel_ch;
  logic             load;
  logic             entry;
  logic             in_range;
`ifdef MUX_SCANNER_PARITY_EN
  logic             par_n;
`endif

  logic [SEL_W-1:0] nxt_ch;
  logic             nxt_wrap;
  logic             any_set;
  logic [SEL_W-1:0] first_ch;
  logic             first_wrap;
  logic             first_any;

  next_enabled_ch #(
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_next (
    .mask   (ch_mask),
    .cur    (ch_out),
    .nxt    (nxt_ch),
    .wrapped(nxt_wrap),
    .any    (any_set)
  );

  // searching above the top index yields the lowest set bit
  next_enabled_ch #(
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W)
  ) u_first (
    .mask   (ch_mask),
    .cur    (CH_TOP),
    .nxt    (first_ch),
    .wrapped(first_wrap),
    .any    (first_any)
  );

  assign entry    = (state != ST_SCAN) || seek;
  assign in_range = {1'b0, sel_in} < CH_LIM;

  always_comb begin
    state_n = ST_IDLE;
    if (en) begin
      state_n = (mode == MODE_SCAN) ? ST_SCAN
                                    : ST_MANUAL;
    end
    data_n  = data_out;
    ch_n    = ch_out;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    cnt_n   = '0;
    seek_n  = 1'b0;
    sel_ch  = ch_out;
    load    = 1'b0;
`ifdef MUX_SCANNER_PARITY_EN
    par_n   = 1'b0;
`endif
    unique case (1'b1)
      state_n == ST_MANUAL: begin
        if (in_range) begin
          sel_ch  = sel_in;
          load    = 1'b1;
          valid_n = 1'b1;
        end else begin
          data_n = '0;
        end
      end
      state_n == ST_SCAN: begin
        if (!any_set) begin
          seek_n = 1'b1;
        end else if (entry) begin
          sel_ch  = first_ch;
          load    = 1'b1;
          valid_n = 1'b1;
        end else if (!ch_mask[ch_out] ||
                     cnt == CNT_LAST) begin
          sel_ch  = nxt_ch;
          wrap_n  = nxt_wrap;
          load    = 1'b1;
          valid_n = 1'b1;
        end else begin
          load    = 1'b1;
          valid_n = 1'b1;
          cnt_n   = cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (load) begin
      data_n = chan[sel_ch];
      ch_n   = sel_ch;
`ifdef MUX_SCANNER_PARITY_EN
      par_n  = ^chan[sel_ch];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      seek      <= 1'b0;
      data_out  <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
`ifdef MUX_SCANNER_PARITY_EN
      parity_out <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      seek      <= seek_n;
      data_out  <= data_n;
      ch_out    <= ch_n;
      out_valid <= valid_n;
      wrap      <= wrap_n;
`ifdef MUX_SCANNER_PARITY_EN
      parity_out <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_param_mux_scanner.sv
// Randomized bench for param_mux_scanner against a
// cycle-level behavioural model (NUM_CH=16, WIDTH=8, DWELL=2).
module tb_param_mux_scanner;

  localparam int NCH = 16;
  localparam int W   = 8;
  localparam int DW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           mode;
  logic [3:0]     sel_in;
  logic [NCH-1:0] ch_mask;
  logic [NCH*W-1:0] data_in;
  logic [W-1:0]   data_out;
  logic [3:0]     ch_out;
  logic           out_valid;
  logic           wrap;
`ifdef MUX_SCANNER_PARITY_EN
  logic           parity_out;
`endif

  param_mux_scanner #(
    .NUM_CH(NCH),
    .WIDTH (W),
    .DWELL (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .sel_in   (sel_in),
    .ch_mask  (ch_mask),
    .data_in  (data_in),
`ifdef MUX_SCANNER_PARITY_EN
    .parity_out(parity_out),
`endif
    .data_out (data_out),
    .ch_out   (ch_out),
    .out_valid(out_valid),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: what the consumer should see
  logic [7:0] e_data;
  int         e_ch;
  bit         e_valid;
  bit         e_wrap;
  int         m_held;
  bit         m_fresh;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [7:0] chan_of(int i);
    return data_in[i*W +: W];
  endfunction

  function automatic int lowest_set();
    for (int k = 0; k < NCH; k++)
      if (ch_mask[k]) return k;
    return 0;
  endfunction

  function automatic int next_set(int cur);
    for (int k = 1; k <= NCH; k++)
      if (ch_mask[(cur + k) % NCH]) return (cur + k) % NCH;
    return cur;
  endfunction

  task automatic present();
    e_data  = chan_of(e_ch);
    e_valid = 1'b1;
  endtask

  task automatic model_edge();
    int n;
    e_wrap = 1'b0;
    if (!rst_n) begin
      e_data  = '0;
      e_ch    = 0;
      e_valid = 1'b0;
      m_held  = 0;
      m_fresh = 1'b1;
    end else if (!en) begin
      e_valid = 1'b0;
      m_fresh = 1'b1;
    end else if (!mode) begin
      m_fresh = 1'b1;
      e_ch    = int'(sel_in);
      present();
    end else if (ch_mask == '0) begin
      e_valid = 1'b0;
      m_fresh = 1'b1;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      e_ch    = lowest_set();
      m_held  = 1;
      present();
    end else if (!ch_mask[e_ch] || m_held >= DW) begin
      n      = next_set(e_ch);
      e_wrap = (n <= e_ch);
      e_ch   = n;
      m_held = 1;
      present();
    end else begin
      m_held++;
      present();
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("data", 32'(data_out), 32'(e_data));
    check("ch", 32'(ch_out), 32'(e_ch));
    check("valid", 32'(out_valid), 32'(e_valid));
    check("wrap", 32'(wrap), 32'(e_wrap));
`ifdef MUX_SCANNER_PARITY_EN
    check("par", 32'(parity_out),
          32'(e_valid ? ^e_data : 1'b0));
`endif
  endtask

  int seq_ch[7] = '{0, 0, 3, 3, 8, 8, 0};
  int seq_wr[7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    mode    = 1'b1;
    sel_in  = '0;
    ch_mask = 16'h0109;
    for (int i = 0; i < NCH; i++)
      data_in[i*W +: W] = 8'(8'h10 + i);
    e_data  = '0;
    e_ch    = 0;
    e_valid = 1'b0;
    e_wrap  = 1'b0;
    m_held  = 0;
    m_fresh = 1'b1;
    #2;

    step();
    step();
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ch", 32'(ch_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);

    rst_n  = 1'b1;
    mode   = 1'b0;
    sel_in = 4'd5;
    step();
    check("man5_data", 32'(data_out), 32'h15);
    check("man5_ch", 32'(ch_out), 32'd5);
    sel_in = 4'd12;
    step();
    check("man12_data", 32'(data_out), 32'h1C);
    check("man12_ch", 32'(ch_out), 32'd12);
    check("man12_valid", 32'(out_valid), 32'd1);

    mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("scan_ch", 32'(ch_out), 32'(seq_ch[i]));
      check("scan_wrap", 32'(wrap), 32'(seq_wr[i]));
    end
    step();
    step();
    check("at3", 32'(ch_out), 32'd3);
    ch_mask = 16'h0101;
    step();
    check("drop", 32'(ch_out), 32'd8);
    step();
    check("drop_hold", 32'(ch_out), 32'd8);

    en = 1'b0;
    step();
    check("dis_valid", 32'(out_valid), 32'd0);
    check("dis_data", 32'(data_out), 32'h18);
    en      = 1'b1;
    ch_mask = 16'h0109;
    step();
    check("reen_ch", 32'(ch_out), 32'd0);

    ch_mask = '0;
    step();
    check("empty_valid", 32'(out_valid), 32'd0);
    ch_mask = 16'h0080;
    step();
    check("one_ch", 32'(ch_out), 32'd7);
    check("one_valid", 32'(out_valid), 32'd1);
    step();
    check("one_nowrap", 32'(wrap), 32'd0);
    step();
    check("one_wrap", 32'(wrap), 32'd1);

    for (int c = 0; c < 500; c++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      en     = ($urandom_range(0, 19) != 0);
      mode   = ($urandom_range(0, 9) > 1);
      sel_in = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       ch_mask = '0;
          1:       ch_mask = 16'(1) << $urandom_range(0, 15);
          default: ch_mask = 16'($urandom) & 16'($urandom);
        endcase
      end
      for (int i = 0; i < NCH; i++)
        data_in[i*W +: W] = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_mux_scanner.md
Name: param_mux_scanner

Overview:
- Parametrised, registered NUM_CH:1 multiplexer of WIDTH-bit channels; generalises the fixed 16:1 single-bit mux tree.
- Two modes: manual select (external sel) and auto-scan (internal counter steps through enabled channels with programmable dwell).
- Sits between multi-channel sources (switch banks, sensor lanes) and a single downstream consumer/display; reports which channel is presented.

Parameters:
- NUM_CH, 16, number of input channels (2..64).
- WIDTH, 8, bits per channel.
- DWELL, 4, cycles each channel is presented in scan mode (>=1).
- SEL_W, $clog2(NUM_CH), derived channel-index width; not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  block enable; 0 forces IDLE.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel_in  in  SEL_W  channel index used in manual mode.
- ch_mask  in  NUM_CH  per-channel enable for scan; bit i = channel i eligible.
- data_in  in  NUM_CH*WIDTH  packed channels; channel i = data_in[i*WIDTH +: WIDTH].
- data_out  out  WIDTH  registered selected data.
- ch_out  out  SEL_W  index of channel presented on data_out.
- out_valid  out  1  data_out/ch_out meaningful.
- wrap  out  1  one-cycle pulse when the scan wraps back to a lower index.

Behaviour:
- Single clock; reset synchronous active-low. rst_n=0 at an edge: data_out=0, ch_out=0, out_valid=0, wrap=0, dwell counter=0, state=IDLE. Reset mid-scan aborts immediately; no partial dwell retained.
- States: IDLE, MANUAL, SCAN. Each edge: en=0 -> IDLE; en=1,mode=0 -> MANUAL; en=1,mode=1 -> SCAN. Mode changes take effect the next edge.
- IDLE: out_valid=0, data_out/ch_out hold last value, wrap=0, dwell counter=0.
- MANUAL: latency 1 cycle: data_out <= channel[sel_in], ch_out <= sel_in, out_valid <= 1. sel_in >= NUM_CH (non-power-of-2 NUM_CH): data_out <= 0, out_valid <= 0, ch_out holds. ch_mask ignored.
- SCAN entry (from IDLE or MANUAL): ch_cur = lowest-index set bit of ch_mask, dwell counter = 0.
- SCAN steady: every cycle data_out <= channel[ch_cur] (live data, 1-cycle latency), ch_out <= ch_cur, out_valid <= 1. Dwell counter increments; at DWELL-1 it clears and ch_cur advances to next set mask bit above ch_cur, wrapping modulo NUM_CH.
- wrap=1 for exactly the cycle the advance lands on an index <= previous ch_cur (incl. single-enabled-channel case); else 0.
- ch_mask all zero in SCAN: out_valid=0, ch_cur holds, counter held at 0, wrap=0; when a bit sets, next edge selects lowest set bit.
- Current channel's mask bit cleared mid-dwell: advance on the next edge regardless of counter; counter restarts.
- DWELL=1: advance every cycle.

Optional Feature:
- Macro MUX_SCANNER_PARITY_EN.
- Defined: extra output parity_out (1 bit), registered alongside data_out, = even parity (XOR) of the WIDTH bits of the selected channel; reset 0; forced 0 whenever out_valid would be 0.
- Undefined: port absent, no parity logic; all other behaviour identical.

Decomposition:
- Shared package mux_scanner_pkg: state encoding typedef (IDLE/MANUAL/SCAN), MODE_MANUAL/MODE_SCAN constants.
- One sub-module: next_enabled_ch (combinational priority search: given mask and current index, return next set index with wrap flag and any-set flag); reused for SCAN entry with current index = NUM_CH-1.

Test Plan (NUM_CH=16, WIDTH=8, DWELL=2, channel i data = 8'h10+i):
- Reset: rst_n=0 two cycles with en=1, mode=1 -> data_out=0, ch_out=0, out_valid=0, wrap=0.
- Manual: en=1, mode=0, sel_in=5 then 12 -> one cycle later data_out=8'h15, ch_out=5, then 8'h1C, ch_out=12, out_valid=1.
- Scan with mask 16'h0109: sequence ch_out 0,0,3,3,8,8,0,... each held 2 cycles; wrap=1 only on cycle ch_out returns to 0.
- Empty mask: mode=1, ch_mask=0 -> out_valid=0; set ch_mask=16'h0080 -> next edge ch_out=7, out_valid=1, wrap pulses each dwell period.
- Mask drop mid-dwell: presenting ch 3 (mask 16'h0109), clear bit 3 in first dwell cycle -> next edge ch_out=8, counter restarted.
- Disable/reset mid-scan: en=0 while ch_out=8 -> out_valid=0, data_out holds 8'h18; re-enable scan -> restarts at ch 0.
